keypad_encoder: RTL and testbench

Scans a 4x4 matrix keypad, debounces it, and encodes one pressed key into the same 4-bit hex code (0-F) that the seven-segment digit decoder takes. It is the input side of the password datapath: its `key_code` feeds entry registers and the display decoders. It emits a one-cycle `key_valid` strobe per debounced press and ignores multi-key chords.

---
 rtl/keypad_pkg.sv | 47 ++++
 rtl/keypad_scan.sv | 101 ++++++++++
 rtl/keypad_encoder.sv | 126 ++++++++++++
 tb/tb_keypad_encoder.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and the key map for the 4x4 keypad encoder.
// The key map produces the 4-bit hex code consumed by the seven-segment decoders.
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_PRESSED  = 2'd2,
    ST_RELEASE  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    RES_NONE  = 2'd0,
    RES_KEY   = 2'd1,
    RES_MULTI = 2'd2
  } scan_res_t;

  // Physical layout: 1 2 3 A / 4 5 6 B / 7 8 9 C / * 0 # D, with * = E and # = F.
  function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    case ({row, col})
      4'd0:    code = 4'h1;
      4'd1:    code = 4'h2;
      4'd2:    code = 4'h3;
      4'd3:    code = 4'hA;
      4'd4:    code = 4'h4;
      4'd5:    code = 4'h5;
      4'd6:    code = 4'h6;
      4'd7:    code = 4'hB;
      4'd8:    code = 4'h7;
      4'd9:    code = 4'h8;
      4'd10:   code = 4'h9;
      4'd11:   code = 4'hC;
      4'd12:   code = 4'hE;
      4'd13:   code = 4'h0;
      4'd14:   code = 4'hF;
      4'd15:   code = 4'hD;
      default: code = 4'h0;
    endcase
    return code;
  endfunction

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
  endfunction

endpackage

// File: rtl/keypad_scan.sv
// Column scanner: drives one column low at a time, synchronizes the rows and
// condenses each full four-column scan into NONE / KEY(code) / MULTI.
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic       scan_done,
  output logic [1:0] result,
  output logic [3:0] code
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DIV_ONE  = DW'(1);

  logic [DW-1:0] div_r;
  logic [1:0]    col_r;
  logic [3:0]    col_n_r;
  // Synchronizer holds rows as active-high, so its zero reset reads as "released".
  logic [3:0]    sync1_r;
  logic [3:0]    sync2_r;
  logic [1:0]    hits_r;
  logic [3:0]    code_r;

  logic          last_s;
  logic [2:0]    pop_s;
  logic [1:0]    hit_row_s;
  logic [2:0]    sum_s;
  logic [1:0]    tot_s;
  logic [3:0]    code_s;
  scan_res_t     res_s;

  // Combine the current column sample with the hits accumulated so far this scan.
  always_comb begin
    last_s = (div_r == DIV_LAST);
    pop_s  = popcount4(sync2_r);
    casez (sync2_r)
      4'b1???: hit_row_s = 2'd3;
      4'b01??: hit_row_s = 2'd2;
      4'b001?: hit_row_s = 2'd1;
      default: hit_row_s = 2'd0;
    endcase
    sum_s = {1'b0, hits_r} + pop_s;
    if (sum_s > 3'd2) begin
      tot_s = 2'd2;
    end else begin
      tot_s = sum_s[1:0];
    end
    if (pop_s != 3'd0) begin
      code_s = key_map(hit_row_s, col_r);
    end else begin
      code_s = code_r;
    end
    case (tot_s)
      2'd0:    res_s = RES_NONE;
      2'd1:    res_s = RES_KEY;
      default: res_s = RES_MULTI;
    endcase
  end

  assign col_n     = col_n_r;
  assign scan_done = last_s && (col_r == 2'd3);
  assign result    = res_s;
  assign code      = code_s;

  // Divider, column rotation, row synchronizer and per-scan hit accumulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_r   <= {DW{1'b0}};
      col_r   <= 2'd0;
      col_n_r <= 4'b1110;
      sync1_r <= 4'h0;
      sync2_r <= 4'h0;
      hits_r  <= 2'd0;
      code_r  <= 4'h0;
    end else begin
      sync1_r <= ~row_n;
      sync2_r <= sync1_r;
      if (last_s) begin
        div_r   <= {DW{1'b0}};
        col_r   <= col_r + 2'd1;
        col_n_r <= ~(4'b0001 << (col_r + 2'd1));
        if (col_r == 2'd3) begin
          hits_r <= 2'd0;
          code_r <= 4'h0;
        end else begin
          hits_r <= tot_s;
          code_r <= code_s;
        end
      end else begin
        div_r <= div_r + DIV_ONE;
      end
    end
  end

endmodule

// File: rtl/keypad_encoder.sv
// 4x4 keypad encoder: debounces whole-scan results and emits one key_valid
// strobe per accepted press, ignoring chords and second keys while one is held.
module keypad_encoder
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [CW-1:0] CNT_TARGET = CW'(DEBOUNCE_SCANS);
  localparam bit            DB_ONE     = (DEBOUNCE_SCANS == 1);

  logic          scan_done_s;
  logic [1:0]    result_s;
  logic [3:0]    scan_code_s;
  scan_res_t     res_s;
  logic [CW-1:0] cnt_inc_s;

  state_t        state_r;
  logic [CW-1:0] cnt_r;
  logic [3:0]    cand_r;
  logic [3:0]    key_code_r;
  logic          key_valid_r;
  logic          key_held_r;

  keypad_scan #(
    .SCAN_DIV(SCAN_DIV)
  ) u_scan (
    .clk       (clk),
    .rst_n     (rst_n),
    .row_n     (row_n),
    .col_n     (col_n),
    .scan_done (scan_done_s),
    .result    (result_s),
    .code      (scan_code_s)
  );

  assign res_s     = scan_res_t'(result_s);
  assign cnt_inc_s = cnt_r + CNT_ONE;
  assign key_code  = key_code_r;
  assign key_valid = key_valid_r;
  assign key_held  = key_held_r;

  // Debounce FSM; only advances on scan boundaries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      cnt_r       <= {CW{1'b0}};
      cand_r      <= 4'h0;
      key_code_r  <= 4'h0;
      key_valid_r <= 1'b0;
      key_held_r  <= 1'b0;
    end else begin
      key_valid_r <= 1'b0;
      if (scan_done_s) begin
        case (state_r)
          ST_IDLE: begin
            if (res_s == RES_KEY) begin
              cand_r <= scan_code_s;
              cnt_r  <= CNT_ONE;
              if (DB_ONE) begin
                key_code_r  <= scan_code_s;
                key_valid_r <= 1'b1;
                key_held_r  <= 1'b1;
                state_r     <= ST_PRESSED;
              end else begin
                state_r <= ST_DEBOUNCE;
              end
            end
          end
          ST_DEBOUNCE: begin
            if ((res_s == RES_KEY) && (scan_code_s == cand_r)) begin
              cnt_r <= cnt_inc_s;
              if (cnt_inc_s == CNT_TARGET) begin
                key_code_r  <= cand_r;
                key_valid_r <= 1'b1;
                key_held_r  <= 1'b1;
                state_r     <= ST_PRESSED;
              end
            end else begin
              state_r <= ST_IDLE;
            end
          end
          ST_PRESSED: begin
            // Any key activity keeps the press alive: no rollover strobes.
            if (res_s == RES_NONE) begin
              cnt_r <= CNT_ONE;
              if (DB_ONE) begin
                key_held_r <= 1'b0;
                state_r    <= ST_IDLE;
              end else begin
                state_r <= ST_RELEASE;
              end
            end
          end
          ST_RELEASE: begin
            if (res_s == RES_NONE) begin
              cnt_r <= cnt_inc_s;
              if (cnt_inc_s == CNT_TARGET) begin
                key_held_r <= 1'b0;
                state_r    <= ST_IDLE;
              end
            end else begin
              state_r <= ST_PRESSED;
            end
          end
          default: begin
            key_held_r <= 1'b0;
            state_r    <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_encoder.sv
// Self-checking bench for keypad_encoder with a behavioural keypad matrix model
// (SCAN_DIV=4, DEBOUNCE_SCANS=3, so one full scan is 16 cycles).
module tb_keypad_encoder;

  localparam int SD   = 4;
  localparam int DB   = 3;
  localparam int SCAN = 4 * SD;

  typedef struct {
    int         wait_n;
    logic [3:0] col_n;
  } col_vec_t;

  typedef struct {
    int         idx;
    logic [3:0] code;
  } key_vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  row_n;
  logic [3:0]  col_n;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic [15:0] pressed = 16'h0000;

  int          checks = 0;
  int          errors = 0;
  int          strobes = 0;
  logic [3:0]  last_code = 4'h0;
  logic        prev_valid = 1'b0;
  logic        double_seen = 1'b0;
  int          base;

  col_vec_t    col_tab[6];
  key_vec_t    key_tab[16];

  keypad_encoder #(
    .SCAN_DIV       (SD),
    .DEBOUNCE_SCANS (DB)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .row_n     (row_n),
    .col_n     (col_n),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  always #5 clk = ~clk;

  // Passive matrix: a pressed key shorts its row to its column when driven low.
  always_comb begin
    row_n = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (pressed[r*4+c] && !col_n[c]) row_n[r] = 1'b0;
      end
    end
  end

  // Strobe monitor.
  always @(negedge clk) begin
    if (key_valid) begin
      strobes   <= strobes + 1;
      last_code <= key_code;
    end
    if (key_valid && prev_valid) double_seen <= 1'b1;
    prev_valid <= key_valid;
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    col_tab[0] = '{0, 4'b1110};
    col_tab[1] = '{3, 4'b1110};
    col_tab[2] = '{1, 4'b1101};
    col_tab[3] = '{4, 4'b1011};
    col_tab[4] = '{4, 4'b0111};
    col_tab[5] = '{4, 4'b1110};

    key_tab[0]  = '{0, 4'h1};  key_tab[1]  = '{1, 4'h2};
    key_tab[2]  = '{2, 4'h3};  key_tab[3]  = '{3, 4'hA};
    key_tab[4]  = '{4, 4'h4};  key_tab[5]  = '{5, 4'h5};
    key_tab[6]  = '{6, 4'h6};  key_tab[7]  = '{7, 4'hB};
    key_tab[8]  = '{8, 4'h7};  key_tab[9]  = '{9, 4'h8};
    key_tab[10] = '{10, 4'h9}; key_tab[11] = '{11, 4'hC};
    key_tab[12] = '{12, 4'hE}; key_tab[13] = '{13, 4'h0};
    key_tab[14] = '{14, 4'hF}; key_tab[15] = '{15, 4'hD};

    // Reset and column rotation.
    wait_cycles(3);
    rst_n = 1'b1;
    check("rst_key_code", 32'(key_code), 32'h0);
    check("rst_key_valid", 32'(key_valid), 32'h0);
    check("rst_key_held", 32'(key_held), 32'h0);
    for (int i = 0; i < 6; i++) begin
      wait_cycles(col_tab[i].wait_n);
      check($sformatf("col_n_step%0d", i), 32'(col_n), 32'(col_tab[i].col_n));
    end

    // Every key position, pressed alone for 6 scans and released.
    for (int i = 0; i < 16; i++) begin
      base = strobes;
      pressed = 16'h0001 << key_tab[i].idx;
      wait_cycles(2 * SCAN);
      check($sformatf("key%0d_early", i), 32'(strobes - base), 32'd0);
      wait_cycles(4 * SCAN);
      check($sformatf("key%0d_strobes", i), 32'(strobes - base), 32'd1);
      check($sformatf("key%0d_code", i), 32'(last_code), 32'(key_tab[i].code));
      check($sformatf("key%0d_held", i), 32'(key_held), 32'd1);
      pressed = 16'h0000;
      wait_cycles(2 * SCAN);
      check($sformatf("key%0d_held_rel2", i), 32'(key_held), 32'd1);
      wait_cycles(2 * SCAN);
      check($sformatf("key%0d_held_rel4", i), 32'(key_held), 32'd0);
    end

    // Bounce on '#': alternate every scan, then hold stable.
    base = strobes;
    for (int i = 0; i < 4; i++) begin
      pressed = (i % 2 == 0) ? 16'h4000 : 16'h0000;
      wait_cycles(SCAN);
    end
    check("bounce_none", 32'(strobes - base), 32'd0);
    pressed = 16'h4000;
    wait_cycles(2 * SCAN);
    check("bounce_stable2", 32'(strobes - base), 32'd0);
    wait_cycles(4 * SCAN);
    check("bounce_strobes", 32'(strobes - base), 32'd1);
    check("bounce_code", 32'(last_code), 32'hF);
    pressed = 16'h0000;
    wait_cycles(5 * SCAN);

    // Chord '1'+'5', then release '5'.
    base = strobes;
    pressed = 16'h0021;
    wait_cycles(10 * SCAN);
    check("chord_none", 32'(strobes - base), 32'd0);
    check("chord_held", 32'(key_held), 32'd0);
    pressed = 16'h0001;
    wait_cycles(2 * SCAN);
    check("chord_rel_early", 32'(strobes - base), 32'd0);
    wait_cycles(3 * SCAN);
    check("chord_rel_strobes", 32'(strobes - base), 32'd1);
    check("chord_rel_code", 32'(last_code), 32'h1);
    pressed = 16'h0000;
    wait_cycles(5 * SCAN);

    // No rollover: 'A' held, then 'D' added.
    base = strobes;
    pressed = 16'h0008;
    wait_cycles(5 * SCAN);
    check("roll_a_strobes", 32'(strobes - base), 32'd1);
    check("roll_a_code", 32'(last_code), 32'hA);
    pressed = 16'h8008;
    wait_cycles(6 * SCAN);
    check("roll_no_second", 32'(strobes - base), 32'd1);
    check("roll_held", 32'(key_held), 32'd1);
    check("roll_code_kept", 32'(key_code), 32'hA);
    pressed = 16'h0000;
    wait_cycles(2 * SCAN);
    check("roll_rel2_held", 32'(key_held), 32'd1);
    wait_cycles(2 * SCAN);
    check("roll_rel4_held", 32'(key_held), 32'd0);

    // Reset while '0' is held in PRESSED.
    base = strobes;
    pressed = 16'h2000;
    wait_cycles(5 * SCAN);
    check("rstmid_strobes", 32'(strobes - base), 32'd1);
    check("rstmid_held_before", 32'(key_held), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rstmid_async_held", 32'(key_held), 32'd0);
    check("rstmid_async_valid", 32'(key_valid), 32'd0);
    check("rstmid_async_code", 32'(key_code), 32'h0);
    check("rstmid_async_col", 32'(col_n), 32'(4'b1110));
    @(negedge clk);
    rst_n = 1'b1;
    base = strobes;
    wait_cycles(2 * SCAN);
    check("rstmid_early", 32'(strobes - base), 32'd0);
    wait_cycles(3 * SCAN);
    check("rstmid_reaccept", 32'(strobes - base), 32'd1);
    check("rstmid_code", 32'(last_code), 32'h0);
    check("rstmid_held_after", 32'(key_held), 32'd1);
    pressed = 16'h0000;
    wait_cycles(5 * SCAN);
    check("final_held", 32'(key_held), 32'd0);

    check("single_cycle_strobe", 32'(double_seen), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
